fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the cpu controller FSM. Owns the program counter, the instruction register and the RAM address/write mux. Fetches one 16-bit instruction from the synchronous-read RAM, presents it to the controller with a valid/ack handshake, and lends the RAM port to the controller for LDR/STR data accesses while the instruction is held.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_unit_pc_counter.sv | 19 +
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared word/address widths and fetch FSM state codes
package fetch_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_HOLD  = 2'b10
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter with load priority over increment, wraps modulo 2^ADDR_W
module pc_counter #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc
);
  logic [ADDR_W-1:0] r_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_target;
    else if (i_inc) r_pc <= r_pc + 1'b1;
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction per ack, holds it for the controller and
// lends the RAM port to controller data accesses while in S_HOLD
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              dmem_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_write,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_e      r_state, w_next;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              w_hold, w_dsel;
  logic [ADDR_W-1:0] w_pc;
  pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (reset),
    .i_inc    (r_state == S_WAIT),
    .i_load   (w_hold & instr_ack & pc_load),
    .i_target (pc_target),
    .o_pc     (w_pc)
  );
  always_comb begin
    w_next = S_FETCH;
    w_hold = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_HOLD;
      S_HOLD: begin
        w_hold = 1'b1;
        w_next = instr_ack ? S_FETCH : S_HOLD;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // controller owns the RAM port only while an instruction is held
  assign w_dsel    = w_hold & dmem_req;
  assign mem_addr  = w_dsel ? dmem_addr : w_pc;
  assign mem_write = w_dsel & dmem_write;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_FETCH;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_HOLD);
      if (r_state == S_WAIT) r_instr <= mem_rdata;
    end
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = w_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table of hold/ack steps plus reset corner sequences,
// fetched words scored against a queue of expected {instr, pc}
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        dmem_req = 1'b0;
  logic [7:0]  dmem_addr = '0;
  logic        dmem_write = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_target = '0;
  logic [7:0]  pc;

  fetch_unit dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_write(dmem_write), .pc_load(pc_load), .pc_target(pc_target), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  typedef struct {
    int         idle;
    logic       load;
    logic [7:0] tgt;
    logic       dreq;
    logic       dwr;
    logic [7:0] daddr;
  } vec_t;

  logic [15:0] ram [256];
  logic [7:0]  addr_s;
  exp_t        q[$];
  logic [7:0]  exp_pc;
  logic [15:0] cur_instr;
  int          wcount = 0;
  int          total = 0;
  int          bad = 0;

  // synchronous-read RAM; address and write strobe sampled just before each rising edge
  always @(negedge clk) begin
    #4;
    addr_s = mem_addr;
    if (mem_write) wcount++;
  end
  always @(posedge clk) mem_rdata <= ram[addr_s];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // outside S_HOLD the port always belongs to the fetch, whatever the controller drives
  always @(negedge clk)
    if (!instr_valid) begin
      chk("idle mem_write", mem_write, 0);
      chk("idle mem_addr", mem_addr, pc);
    end

  task automatic wait_valid(input int lat, input string tag);
    int n = 0;
    bit got = 0;
    exp_t e;
    while (!got && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      got = instr_valid;
    end
    chk({tag, " latency"}, n, got ? lat : 0);
    if (q.size() == 0) begin
      chk({tag, " queue"}, 0, 1);
    end else begin
      e = q.pop_front();
      chk({tag, " instr"}, instr, e.instr);
      chk({tag, " pc"}, pc, e.pc);
      cur_instr = e.instr;
    end
  endtask

  task automatic run_step(input vec_t v);
    logic [7:0] fa;
    @(negedge clk);
    dmem_req = v.dreq; dmem_write = v.dwr; dmem_addr = v.daddr;
    pc_load = v.load; pc_target = v.tgt; instr_ack = 1'b0; wcount = 0;
    for (int i = 0; i < v.idle; i++) begin
      #1;
      chk("hold mem_addr", mem_addr, v.dreq ? v.daddr : exp_pc);
      chk("hold mem_write", mem_write, v.dreq & v.dwr);
      @(negedge clk);
      chk("hold pc", pc, exp_pc);
      chk("hold instr", instr, cur_instr);
      chk("hold valid", instr_valid, 1);
    end
    instr_ack = 1'b1;
    #1;
    chk("ack mem_addr", mem_addr, v.dreq ? v.daddr : exp_pc);
    chk("ack mem_write", mem_write, v.dreq & v.dwr);
    fa = v.load ? v.tgt : exp_pc;
    q.push_back('{ram[fa], fa + 8'd1});
    exp_pc = fa + 8'd1;
    wait_valid(3, "ack");
    chk("write cycles", wcount, (v.dreq & v.dwr) ? v.idle + 1 : 0);
    instr_ack = 1'b0; pc_load = 1'b0; dmem_req = 1'b0; dmem_write = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " mem_write"}, mem_write, 0);
    chk({tag, " valid"}, instr_valid, 0);
    chk({tag, " instr"}, instr, 0);
    chk({tag, " pc"}, pc, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
  endtask

  vec_t vecs [9];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {~i[7:0], i[7:0]} ^ 16'h3C5A;
    ram[0] = 16'hD105;
    ram[1] = 16'hA0C8;
    vecs[0] = '{0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{0,  1'b0, 8'h00, 1'b1, 1'b1, 8'h40};
    vecs[3] = '{3,  1'b1, 8'h20, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{2,  1'b0, 8'h00, 1'b1, 1'b0, 8'h55};
    vecs[5] = '{0,  1'b1, 8'hFE, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[8] = '{4,  1'b0, 8'h00, 1'b1, 1'b1, 8'h80};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    reset = 1'b1;
    q.push_back('{ram[0], 8'd1});
    exp_pc = 8'd1;
    wait_valid(2, "boot");

    for (int i = 0; i < 9; i++) run_step(vecs[i]);

    // reset while the RAM read is in flight
    @(negedge clk); instr_ack = 1'b1;
    @(negedge clk); instr_ack = 1'b0;
    @(negedge clk); #2 reset = 1'b0;
    #1 check_reset("rst wait");
    @(negedge clk);
    reset = 1'b1;
    q.push_back('{ram[0], 8'd1});
    exp_pc = 8'd1;
    wait_valid(2, "rst wait boot");

    // reset in the middle of a controller store
    @(negedge clk);
    dmem_req = 1'b1; dmem_write = 1'b1; dmem_addr = 8'h40;
    #1;
    chk("store mem_write", mem_write, 1);
    chk("store mem_addr", mem_addr, 8'h40);
    #1 reset = 1'b0;
    #1 check_reset("rst hold");
    @(negedge clk);
    dmem_req = 1'b0; dmem_write = 1'b0;
    reset = 1'b1;
    q.push_back('{ram[0], 8'd1});
    exp_pc = 8'd1;
    wait_valid(2, "rst hold boot");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
